vend_controller: RTL and testbench

//   Credit-tracking sequencer for the coin-operated vending datapath. Counts
//   5/10 coin inputs, holds credit, vends one of two products on selection,

---
 rtl/vend_controller_pkg.sv | 20 ++
 rtl/vend_controller_edge.sv | 30 +++
 rtl/vend_controller.sv | 132 +++++++++++++
 tb/tb_vend_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vend_controller_pkg.sv
// Shared encodings for the vending controller: FSM states, coin values, selector codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vend_controller_pkg;

  typedef enum logic [1:0] {
    VS_IDLE    = 2'd0,
    VS_COLLECT = 2'd1,
    VS_VEND    = 2'd2,
    VS_CHANGE  = 2'd3
  } vend_state_t;

  localparam int COIN5  = 5;
  localparam int COIN10 = 10;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;

endpackage

// File: rtl/vend_controller_edge.sv
// Turns coin-acceptor levels into single-cycle rise pulses against last cycle's sample.
// Latency: pulse is combinational in the cycle the level first goes high.
// Backpressure: none; a level held high produces exactly one pulse.
module coin_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in5,
  input  logic in10,
  output logic p5,
  output logic p10
);

  logic hist5;
  logic hist10;

  // Remember the previous-cycle coin levels; cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist5  <= 1'b0;
      hist10 <= 1'b0;
    end else begin
      hist5  <= in5;
      hist10 <= in10;
    end
  end

  assign p5  = in5  & ~hist5;
  assign p10 = in10 & ~hist10;

endmodule

// File: rtl/vend_controller.sv
// Credit-tracking vend sequencer: counts coins, vends A/B, pulses door, refunds change in 5s.
// Latency: coin -> credit next cycle; sel -> door next cycle; first change5 three cycles after sel.
// Backpressure: coins arriving while busy, on cancel/vend, or overflowing credit pulse reject.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter int CREDIT_W   = 6,
  parameter int PRICE_A    = 15,
  parameter int PRICE_B    = 20,
  parameter int MAX_CREDIT = 35
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in5,
  input  logic                in10,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic                door,
  output logic                change5,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] C5    = CREDIT_W'(COIN5);
  localparam logic [CREDIT_W-1:0] C10   = CREDIT_W'(COIN10);
  localparam logic [CREDIT_W-1:0] PA    = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB    = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0]   LIMIT = (CREDIT_W+1)'(MAX_CREDIT);

  logic                p5;
  logic                p10;
  vend_state_t         state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic                coin;
  logic                fits;
  logic                sel_ok;

  coin_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .in5   (in5),
    .in10  (in10),
    .p5    (p5),
    .p10   (p10)
  );

  // Decode this cycle's coin value (both at once is one 15-unit coin) and the selected price.
  always_comb begin
    coin_val = '0;
    price    = '0;
    sel_ok   = 1'b0;
    if (p5 && p10)  coin_val = C5 + C10;
    else if (p10)   coin_val = C10;
    else if (p5)    coin_val = C5;
    coin = p5 | p10;
    sum  = {1'b0, credit} + {1'b0, coin_val};
    fits = (sum <= LIMIT);
    case (sel)
      SEL_A: begin price = PA; sel_ok = 1'b1; end
      SEL_B: begin price = PB; sel_ok = 1'b1; end
      default: begin price = '0; sel_ok = 1'b0; end
    endcase
  end

  // Sequencer and credit register; every output is a registered pulse or level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= VS_IDLE;
      credit  <= '0;
      door    <= 1'b0;
      change5 <= 1'b0;
      reject  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      door    <= 1'b0;
      change5 <= 1'b0;
      reject  <= 1'b0;
      case (state)
        VS_IDLE: begin
          if (coin) begin
            if (fits) begin
              credit <= sum[CREDIT_W-1:0];
              state  <= VS_COLLECT;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        VS_COLLECT: begin
          if (cancel) begin
            // Refund everything; a coin in the same cycle is refused.
            state  <= VS_CHANGE;
            busy   <= 1'b1;
            reject <= coin;
          end else if (sel_ok && credit >= price) begin
            state  <= VS_VEND;
            door   <= 1'b1;
            credit <= credit - price;
            busy   <= 1'b1;
            reject <= coin;
          end else if (coin) begin
            if (fits) credit <= sum[CREDIT_W-1:0];
            else      reject <= 1'b1;
          end
        end
        VS_VEND: begin
          reject <= coin;
          if (credit != '0) begin
            state <= VS_CHANGE;
          end else begin
            state <= VS_IDLE;
            busy  <= 1'b0;
          end
        end
        VS_CHANGE: begin
          reject <= coin;
          if (credit != '0) begin
            change5 <= 1'b1;
            credit  <= credit - C5;
          end else begin
            state <= VS_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: coin counting, vend, change, reject and reset cases.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at that point.
// Backpressure: none; the bench drives every input every cycle.
module tb_vend_controller;
  import vend_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in5 = 1'b0;
  logic       in10 = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       door;
  logic       change5;
  logic       reject;
  logic [5:0] credit;
  logic       busy;

  int total = 0;
  int bad   = 0;

  vend_controller dut (
    .clk     (clk),
    .reset   (reset),
    .in5     (in5),
    .in10    (in10),
    .sel     (sel),
    .cancel  (cancel),
    .door    (door),
    .change5 (change5),
    .reject  (reject),
    .credit  (credit),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coin10_once();
    in10 = 1'b1; tick(); in10 = 1'b0; tick();
  endtask

  task automatic coin5_once();
    in5 = 1'b1; tick(); in5 = 1'b0; tick();
  endtask

  task automatic drain();
    cancel = 1'b1; tick(); cancel = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int n;
    logic door_seen;

    // 1: reset held three cycles
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_door", 32'(door), 0);
    chk("rst_change5", 32'(change5), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dut.state), 32'(VS_IDLE));

    // 2: held in10 then held in5 count once each, vend A with exact credit
    in10 = 1'b1; tick();
    chk("t2_credit10", 32'(credit), 10);
    tick(); tick();
    chk("t2_held10", 32'(credit), 10);
    in10 = 1'b0; in5 = 1'b1; tick();
    chk("t2_credit15", 32'(credit), 15);
    tick(); tick();
    chk("t2_held5", 32'(credit), 15);
    in5 = 1'b0; sel = SEL_A; tick();
    chk("t2_door", 32'(door), 1);
    chk("t2_credit0", 32'(credit), 0);
    chk("t2_busy", 32'(busy), 1);
    sel = SEL_NONE; tick();
    chk("t2_door_off", 32'(door), 0);
    chk("t2_no_change", 32'(change5), 0);
    chk("t2_idle", 32'(dut.state), 32'(VS_IDLE));
    chk("t2_busy_off", 32'(busy), 0);

    // 3: credit 30, vend B, two change pulses back-to-back
    repeat (3) coin10_once();
    chk("t3_credit30", 32'(credit), 30);
    sel = SEL_B; tick();
    chk("t3_door", 32'(door), 1);
    chk("t3_credit10", 32'(credit), 10);
    sel = SEL_NONE; tick();
    chk("t3_vend_door_off", 32'(door), 0);
    chk("t3_vend_no_chg", 32'(change5), 0);
    tick();
    chk("t3_chg1", 32'(change5), 1);
    chk("t3_credit5", 32'(credit), 5);
    tick();
    chk("t3_chg2", 32'(change5), 1);
    chk("t3_credit0", 32'(credit), 0);
    tick();
    chk("t3_chg_end", 32'(change5), 0);
    chk("t3_idle", 32'(dut.state), 32'(VS_IDLE));
    chk("t3_busy", 32'(busy), 0);

    // 4: full credit refuses a coin, cancel refunds seven pulses
    repeat (3) coin10_once();
    coin5_once();
    chk("t4_credit35", 32'(credit), 35);
    in5 = 1'b1; tick();
    chk("t4_reject", 32'(reject), 1);
    chk("t4_credit_kept", 32'(credit), 35);
    in5 = 1'b0; tick();
    chk("t4_reject_off", 32'(reject), 0);
    cancel = 1'b1; tick();
    cancel = 1'b0;
    chk("t4_change_state", 32'(dut.state), 32'(VS_CHANGE));
    chk("t4_busy", 32'(busy), 1);
    n = 0;
    door_seen = 1'b0;
    repeat (10) begin
      tick();
      if (change5) n++;
      if (door) door_seen = 1'b1;
    end
    chk("t4_pulses", 32'(n), 7);
    chk("t4_no_door", 32'(door_seen), 0);
    chk("t4_credit0", 32'(credit), 0);
    chk("t4_idle", 32'(dut.state), 32'(VS_IDLE));

    // 5: simultaneous coins are one 15-unit coin; overflow refused; underpriced select ignored
    in5 = 1'b1; in10 = 1'b1; tick();
    chk("t5_credit15", 32'(credit), 15);
    chk("t5_no_reject", 32'(reject), 0);
    in5 = 1'b0; in10 = 1'b0; tick();
    coin10_once();
    chk("t5_credit25", 32'(credit), 25);
    in5 = 1'b1; in10 = 1'b1; tick();
    chk("t5_reject", 32'(reject), 1);
    chk("t5_credit_kept", 32'(credit), 25);
    in5 = 1'b0; in10 = 1'b0; tick();
    drain();
    chk("t5_drained", 32'(credit), 0);
    coin10_once();
    chk("t5_credit10", 32'(credit), 10);
    sel = SEL_A; tick();
    chk("t5_no_door", 32'(door), 0);
    chk("t5_credit_hold", 32'(credit), 10);
    chk("t5_collect", 32'(dut.state), 32'(VS_COLLECT));
    sel = SEL_NONE;
    drain();

    // 6: coin during refund is refused, reset mid-refund stops pulses
    coin10_once();
    coin10_once();
    chk("t6_credit20", 32'(credit), 20);
    cancel = 1'b1; tick();
    cancel = 1'b0;
    chk("t6_change_state", 32'(dut.state), 32'(VS_CHANGE));
    in5 = 1'b1; tick();
    chk("t6_chg1", 32'(change5), 1);
    chk("t6_reject", 32'(reject), 1);
    chk("t6_credit15", 32'(credit), 15);
    in5 = 1'b0; tick();
    chk("t6_chg2", 32'(change5), 1);
    chk("t6_credit10", 32'(credit), 10);
    reset = 1'b0; tick();
    chk("t6_rst_chg", 32'(change5), 0);
    chk("t6_rst_credit", 32'(credit), 0);
    chk("t6_rst_idle", 32'(dut.state), 32'(VS_IDLE));
    chk("t6_rst_busy", 32'(busy), 0);
    reset = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      if (change5 || door) n++;
    end
    chk("t6_quiet", 32'(n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
